feature_frame_buffer: RTL and testbench

Ping-pong input buffer that sits directly upstream of `dense1` (42 -> 24) in the denoise datapath. It accepts the 42 IEEE-754 single-precision band features one word per cycle over a valid/ready stream, checks frame length, and presents each complete frame as the packed 42×32-bit bus that `dense1` reads as `in`. Two banks let frame N+1 fill while `dense1` consumes frame N.

---
 rtl/feature_frame_buffer.sv | 76 +++++++
 tb/tb_feature_frame_buffer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/feature_frame_buffer.sv
// feature_frame_buffer: ping-pong 42-word frame buffer feeding dense1; define DENOISE_FEAT_SANITIZE_EN to zero non-finite words.
module feature_frame_buffer #(
  parameter int FLOAT = 32,
  parameter int NB_FEAT = 42
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [FLOAT-1:0]         s_data,
  input  logic                     s_last,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic [NB_FEAT*FLOAT-1:0] frame_data,
  output logic                     err_len,
  output logic                     san_flag
);
  localparam int IW = $clog2(NB_FEAT);
  typedef enum logic {FILL, RESYNC} state_t;
  state_t state, state_nx;
  logic run, wr_bank, rd_bank, acc, fill_acc, at_end, done, bad, take, nonfin;
  logic [1:0] full;
  logic [IW-1:0] widx, widx_nx;
  logic [FLOAT-1:0] wdata;
  logic [NB_FEAT*FLOAT-1:0] bank [2];
  assign s_ready = run & ~full[wr_bank];
  assign acc = s_valid & s_ready;
  assign fill_acc = acc & (state == FILL);
  assign at_end = widx == IW'(NB_FEAT-1);
  assign frame_valid = full[rd_bank];
  assign frame_data = bank[rd_bank];
  assign take = frame_valid & frame_ready;
`ifdef DENOISE_FEAT_SANITIZE_EN
  assign nonfin = &s_data[FLOAT-2 -: 8];
`else
  assign nonfin = 1'b0;
`endif
  assign wdata = nonfin ? '0 : s_data;
  always_comb begin
    done = fill_acc & at_end & s_last;
    bad = fill_acc & (at_end ^ s_last);
    widx_nx = fill_acc ? ((at_end | s_last) ? '0 : widx + 1'b1) : widx;
    state_nx = !acc ? state :
               state == FILL ? ((at_end & ~s_last) ? RESYNC : FILL) :
               (s_last ? FILL : RESYNC);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FILL;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run <= 1'b0;
      full <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      widx <= '0;
      err_len <= 1'b0;
      san_flag <= 1'b0;
      bank[0] <= '0;
      bank[1] <= '0;
    end else begin
      run <= 1'b1;
      widx <= widx_nx;
      err_len <= bad;
      san_flag <= fill_acc & nonfin;
      if (fill_acc) bank[wr_bank][widx*FLOAT +: FLOAT] <= wdata;
      if (done) begin
        full[wr_bank] <= 1'b1;
        wr_bank <= ~wr_bank;
      end
      if (take) begin
        full[rd_bank] <= 1'b0;
        rd_bank <= ~rd_bank;
      end
    end
endmodule

// File: tb/tb_feature_frame_buffer.sv
// tb_feature_frame_buffer: frame-queue model checked every cycle, plus literal per-test expectations.
module tb_feature_frame_buffer;
  localparam int NB = 42;
  typedef logic [NB*32-1:0] frame_t;
  logic clk = 0, rst_n = 0, s_valid = 0, s_last = 0, frame_ready = 0;
  logic s_ready, frame_valid, err_len, san_flag;
  logic [31:0] s_data = '0;
  frame_t frame_data;
  int vec = 0, miss = 0;
  int err_seen = 0, san_seen = 0, vcnt = 0;
  frame_t q[$], log_q[$];
  logic [31:0] cur[$];
  logic drop = 0, err_e = 0, san_e = 0, run_m = 0;

  feature_frame_buffer dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_data(frame_data), .err_len(err_len), .san_flag(san_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s act=%h exp=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_frame(input frame_t act, input frame_t exp);
    vec++;
    if (act !== exp) begin
      miss++;
      for (int k = 0; k < NB; k++)
        if (act[k*32 +: 32] !== exp[k*32 +: 32]) begin
          $display("FAIL frame_data word %0d act=%h exp=%h at %0t", k, act[k*32 +: 32], exp[k*32 +: 32], $time);
          break;
        end
    end
  endtask

  always @(negedge clk) begin
    logic acc, hs;
    logic [31:0] w;
    frame_t f;
    if (!rst_n) begin
      q.delete();
      cur.delete();
      drop = 0; err_e = 0; san_e = 0; run_m = 0;
      chk("rst_s_ready", {31'd0, s_ready}, 0);
      chk("rst_frame_valid", {31'd0, frame_valid}, 0);
      chk("rst_err_len", {31'd0, err_len}, 0);
      chk("rst_san_flag", {31'd0, san_flag}, 0);
      chk_frame(frame_data, '0);
    end else begin
      chk("s_ready", {31'd0, s_ready}, {31'd0, run_m && q.size() < 2});
      chk("frame_valid", {31'd0, frame_valid}, {31'd0, q.size() != 0});
      if (q.size() != 0) chk_frame(frame_data, q[0]);
      chk("err_len", {31'd0, err_len}, {31'd0, err_e});
      chk("san_flag", {31'd0, san_flag}, {31'd0, san_e});
      if (err_len) err_seen++;
      if (san_flag) san_seen++;
      if (frame_valid) vcnt++;
      acc = s_valid && run_m && q.size() < 2;
      hs = q.size() != 0 && frame_ready;
      if (hs) begin
        log_q.push_back(frame_data);
        void'(q.pop_front());
      end
      err_e = 0; san_e = 0;
      if (acc) begin
        if (drop) begin
          if (s_last) drop = 0;
        end else begin
          w = s_data;
`ifdef DENOISE_FEAT_SANITIZE_EN
          if (w[30:23] == 8'hFF) begin w = 0; san_e = 1; end
`endif
          cur.push_back(w);
          if (s_last) begin
            if (cur.size() == NB) begin
              f = '0;
              for (int k = 0; k < NB; k++) f[k*32 +: 32] = cur[k];
              q.push_back(f);
            end else err_e = 1;
            cur.delete();
          end else if (cur.size() == NB) begin
            err_e = 1; drop = 1;
            cur.delete();
          end
        end
      end
      run_m = 1;
    end
  end

  task automatic send_word(input logic [31:0] d, input logic l);
    int t = 0;
    s_valid = 1; s_data = d; s_last = l;
    do @(negedge clk); while (!s_ready && ++t < 300);
    if (!s_ready) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    s_valid = 0; s_last = 0;
  endtask

  task automatic send_frame(input logic [31:0] base, input int n, input int lastk, input logic bad56);
    logic [31:0] d;
    for (int k = 0; k < n; k++) begin
      d = base + k;
      if (bad56 && k == 5) d = 32'h7FC00000;
      if (bad56 && k == 6) d = 32'hFF800000;
      send_word(d, k == lastk);
    end
  endtask

  function automatic logic [31:0] log_word(input int i, input int k);
    frame_t f;
    f = log_q[i];
    return f[k*32 +: 32];
  endfunction

  initial begin
    int e0, s0, v0, l0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    frame_ready = 1;
    v0 = vcnt;
    send_frame(32'h3F800000, 42, 41, 0);
    repeat (4) @(posedge clk); #1;
    chk("t1_valid_cycles", vcnt - v0, 1);
    chk("t1_frames", log_q.size(), 1);
    chk("t1_word0", log_word(0, 0), 32'h3F800000);
    chk("t1_word41", log_word(0, 41), 32'h3F800029);

    frame_ready = 0;
    l0 = log_q.size();
    fork
      begin
        send_frame(32'h1000, 42, 41, 0);
        send_frame(32'h2000, 42, 41, 0);
        send_frame(32'h3000, 42, 41, 0);
      end
      begin
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("t2_blocked_ready", {31'd0, s_ready}, 0);
        chk("t2_blocked_valid", {31'd0, frame_valid}, 1);
        repeat (30) @(posedge clk);
        #1 frame_ready = 1;
      end
    join
    repeat (6) @(posedge clk); #1;
    chk("t2_frames", log_q.size() - l0, 3);
    chk("t2_order1", log_word(l0, 0), 32'h1000);
    chk("t2_order2", log_word(l0 + 1, 0), 32'h2000);
    chk("t2_order3", log_word(l0 + 2, 41), 32'h3029);

    e0 = err_seen; l0 = log_q.size();
    send_frame(32'h4000, 11, 10, 0);
    repeat (3) @(posedge clk); #1;
    chk("t3_err", err_seen - e0, 1);
    chk("t3_no_frame", log_q.size() - l0, 0);
    send_frame(32'h5000, 42, 41, 0);
    repeat (3) @(posedge clk); #1;
    chk("t3_good", log_word(log_q.size() - 1, 20), 32'h5014);

    e0 = err_seen; l0 = log_q.size();
    send_frame(32'h6000, 45, 44, 0);
    send_frame(32'h7000, 42, 41, 0);
    repeat (3) @(posedge clk); #1;
    chk("t4_err", err_seen - e0, 1);
    chk("t4_frames", log_q.size() - l0, 1);
    chk("t4_word0", log_word(l0, 0), 32'h7000);

    s0 = san_seen;
    send_frame(32'h8000, 42, 41, 1);
    repeat (3) @(posedge clk); #1;
`ifdef DENOISE_FEAT_SANITIZE_EN
    chk("t5_w5", log_word(log_q.size() - 1, 5), 32'h0);
    chk("t5_w6", log_word(log_q.size() - 1, 6), 32'h0);
    chk("t5_san", san_seen - s0, 2);
`else
    chk("t5_w5", log_word(log_q.size() - 1, 5), 32'h7FC00000);
    chk("t5_w6", log_word(log_q.size() - 1, 6), 32'hFF800000);
    chk("t5_san", san_seen - s0, 0);
`endif
    chk("t5_w7", log_word(log_q.size() - 1, 7), 32'h8007);

    frame_ready = 0;
    send_frame(32'h9000, 42, 41, 0);
    send_frame(32'hA000, 20, 99, 0);
    rst_n = 0;
    #1;
    chk("t6_rst_valid", {31'd0, frame_valid}, 0);
    chk("t6_rst_ready", {31'd0, s_ready}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    frame_ready = 1;
    l0 = log_q.size();
    send_frame(32'hB000, 42, 41, 0);
    repeat (3) @(posedge clk); #1;
    chk("t6_frames", log_q.size() - l0, 1);
    chk("t6_word0", log_word(l0, 0), 32'hB000);
    chk("t6_word41", log_word(l0, 41), 32'hB029);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
